// File: rtl/mac_out_serializer_pkg.sv
// Shared constants for the MAC output serializer: precision-mode encodings,
// FSM state encoding and the mode sanitizer.
package mac_out_serializer_pkg;

  localparam logic [1:0] MAC_SINGLE = 2'b00;
  localparam logic [1:0] MAC_DUAL   = 2'b01;
  localparam logic [1:0] MAC_QUAD   = 2'b10;

  typedef enum logic {
    MAC_SER_IDLE = 1'b0,
    MAC_SER_SEND = 1'b1
  } mac_ser_state_e;

  // Reserved mode encodings frame like single precision.
  function automatic logic [1:0] mac_mode_sanitize(input logic [1:0] mode);
    logic [1:0] res;
    case (mode)
      MAC_DUAL: res = MAC_DUAL;
      MAC_QUAD: res = MAC_QUAD;
      default:  res = MAC_SINGLE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mac_ser_last_gen.sv
// Combinational end-of-result decision for the serializer: is beat 'cnt'
// the final beat of a result under precision 'mode'.
module mac_ser_last_gen
  import mac_out_serializer_pkg::*;
#(
  parameter int BEATS_PER_WORD = 2,
  parameter int CNT_W          = 3
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       mode,
  output logic             last
);

  logic [31:0] group_s;

  // Result length in beats, then last on every group boundary.
  always_comb begin
    group_s = 32'(BEATS_PER_WORD);
    case (mode)
      MAC_DUAL: group_s = 32'(2 * BEATS_PER_WORD);
      MAC_QUAD: group_s = 32'(4 * BEATS_PER_WORD);
      default:  group_s = 32'(BEATS_PER_WORD);
    endcase
    last = (((32'(cnt) + 32'd1) % group_s) == 32'd0);
  end

endmodule

// File: rtl/mac_out_serializer.sv
// Captures four accumulator words and streams them LSB-first as narrow beats
// over valid/ready. Optional out_parity port under MAC_OUT_SER_PARITY_EN.
module mac_out_serializer
  import mac_out_serializer_pkg::*;
#(
  parameter int MAC_MIN_WIDTH = 8,
  parameter int MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH,
  parameter int OUT_WIDTH     = MAC_ACC_WIDTH / 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap,
  input  logic [1:0]               mode,
  input  logic [MAC_ACC_WIDTH-1:0] in0,
  input  logic [MAC_ACC_WIDTH-1:0] in1,
  input  logic [MAC_ACC_WIDTH-1:0] in2,
  input  logic [MAC_ACC_WIDTH-1:0] in3,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     cap_drop
`ifdef MAC_OUT_SER_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  localparam int BEATS_PER_WORD = MAC_ACC_WIDTH / OUT_WIDTH;
  localparam int TOTAL_BEATS    = 4 * BEATS_PER_WORD;
  localparam int CNT_W          = $clog2(TOTAL_BEATS);
  localparam int SHIFT_W        = 4 * MAC_ACC_WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_BEATS - 1);

  mac_ser_state_e     state_r, state_nxt_s;
  logic [SHIFT_W-1:0] shift_r, shift_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [1:0]         mode_r, mode_nxt_s;
  logic               out_last_r, last_nxt_s;
  logic               cap_drop_r, drop_nxt_s;
  logic               xfer_s, final_s;

`ifdef MAC_OUT_SER_PARITY_EN
  logic               out_parity_r;

  function automatic logic even_parity(input logic [OUT_WIDTH-1:0] data);
    return ^data;
  endfunction
`endif

  assign xfer_s  = (state_r == MAC_SER_SEND) && out_ready;
  assign final_s = (cnt_r == LAST_CNT);

  // Next-state, shift-register and drop decision.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    cnt_nxt_s   = cnt_r;
    mode_nxt_s  = mode_r;
    drop_nxt_s  = 1'b0;
    case (state_r)
      MAC_SER_IDLE: begin
        if (cap) begin
          state_nxt_s = MAC_SER_SEND;
          shift_nxt_s = {in3, in2, in1, in0};
          mode_nxt_s  = mac_mode_sanitize(mode);
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = MAC_SER_IDLE;
        end
      end
      MAC_SER_SEND: begin
        if (xfer_s && final_s) begin
          // A capture on the closing edge chains the next stream with no bubble.
          if (cap) begin
            state_nxt_s = MAC_SER_SEND;
            shift_nxt_s = {in3, in2, in1, in0};
            mode_nxt_s  = mac_mode_sanitize(mode);
          end else begin
            state_nxt_s = MAC_SER_IDLE;
            shift_nxt_s = shift_r >> OUT_WIDTH;
          end
          cnt_nxt_s = {CNT_W{1'b0}};
        end else if (xfer_s) begin
          shift_nxt_s = shift_r >> OUT_WIDTH;
          cnt_nxt_s   = cnt_r + CNT_W'(1);
          drop_nxt_s  = cap;
        end else begin
          drop_nxt_s  = cap;
        end
      end
      default: begin
        state_nxt_s = MAC_SER_IDLE;
        shift_nxt_s = {SHIFT_W{1'b0}};
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  mac_ser_last_gen #(
    .BEATS_PER_WORD (BEATS_PER_WORD),
    .CNT_W          (CNT_W)
  ) u_last_gen (
    .cnt  (cnt_nxt_s),
    .mode (mode_nxt_s),
    .last (last_nxt_s)
  );

  // State and output registers; out_last is precomputed for the next beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= MAC_SER_IDLE;
      shift_r    <= {SHIFT_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      mode_r     <= MAC_SINGLE;
      out_last_r <= 1'b0;
      cap_drop_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      shift_r    <= shift_nxt_s;
      cnt_r      <= cnt_nxt_s;
      mode_r     <= mode_nxt_s;
      out_last_r <= (state_nxt_s == MAC_SER_SEND) && last_nxt_s;
      cap_drop_r <= drop_nxt_s;
    end
  end

`ifdef MAC_OUT_SER_PARITY_EN
  // Parity tracks the beat register so it holds under back-pressure too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_parity_r <= 1'b0;
    end else begin
      out_parity_r <= even_parity(shift_nxt_s[OUT_WIDTH-1:0]);
    end
  end

  assign out_parity = out_parity_r;
`endif

  assign out_data  = shift_r[OUT_WIDTH-1:0];
  assign out_valid = (state_r == MAC_SER_SEND);
  assign busy      = (state_r == MAC_SER_SEND);
  assign out_last  = out_last_r;
  assign cap_drop  = cap_drop_r;

endmodule

// File: tb/tb_mac_out_serializer.sv
// Self-checking bench for mac_out_serializer: framing table, directed
// handshake/capture/reset sequences and randomized traffic against a beat-queue model.
module tb_mac_out_serializer;
  import mac_out_serializer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cap = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] in0 = 32'h0, in1 = 32'h0, in2 = 32'h0, in3 = 32'h0;
  logic [15:0] out_data;
  logic        out_valid, out_last, busy, cap_drop;
`ifdef MAC_OUT_SER_PARITY_EN
  logic        out_parity;
`endif

  mac_out_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .cap       (cap),
    .mode      (mode),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .cap_drop  (cap_drop)
`ifdef MAC_OUT_SER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending {last, data} beats, beats left, expected drop.
  logic [16:0] exp_q[$];
  int          rem      = 0;
  logic        exp_drop = 1'b0;
  int          pops     = 0;

  function automatic int group_of(input logic [1:0] m);
    case (m)
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 2;
    endcase
  endfunction

  task automatic push_stream(input logic [127:0] pk, input logic [1:0] m);
    for (int b = 0; b < 8; b++) begin
      exp_q.push_back({((b + 1) % group_of(m)) == 0, pk[16*b +: 16]});
    end
    rem = 8;
  endtask

  // One clock cycle: check outputs at the negedge, drive inputs, advance the model.
  task automatic step(input logic c, input logic r, input logic [127:0] pk, input logic [1:0] m);
    chk("out_valid", 32'(out_valid), 32'(rem > 0));
    chk("busy", 32'(busy), 32'(rem > 0));
    chk("cap_drop", 32'(cap_drop), 32'(exp_drop));
    if (rem > 0) begin
      chk("out_data", 32'(out_data), 32'(exp_q[0][15:0]));
      chk("out_last", 32'(out_last), 32'(exp_q[0][16]));
`ifdef MAC_OUT_SER_PARITY_EN
      chk("out_parity", 32'(out_parity), 32'(^exp_q[0][15:0]));
`endif
    end
    cap = c; out_ready = r; mode = m;
    {in3, in2, in1, in0} = pk;
    exp_drop = 1'b0;
    if (rem > 0 && r) begin
      void'(exp_q.pop_front());
      rem--;
      pops++;
    end
    if (c) begin
      if (rem == 0) push_stream(pk, m);
      else exp_drop = 1'b1;
    end
    @(negedge clk);
  endtask

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] last_mask;
  } vec_t;

  vec_t         tbl[4];
  logic [127:0] pk0, pk1, pkr;
  int           guard;

  initial begin
    pk0 = {32'h77778888, 32'h55556666, 32'h33334444, 32'h11112222};
    pk1 = {32'hA5A5C3C3, 32'h0F0F1234, 32'h9999AAAA, 32'h0102FEDC};
    tbl[0] = '{"quad",   2'b10, 8'b1000_0000};
    tbl[1] = '{"single", 2'b00, 8'b1010_1010};
    tbl[2] = '{"dual",   2'b01, 8'b1000_1000};
    tbl[3] = '{"rsvd11", 2'b11, 8'b1010_1010};

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(cap_drop), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Framing table, sink always ready.
    for (int v = 0; v < 4; v++) begin
      cap = 1'b1; out_ready = 1'b1; mode = tbl[v].mode;
      {in3, in2, in1, in0} = pk0;
      @(negedge clk); cap = 1'b0;
      for (int b = 0; b < 8; b++) begin
        chk({tbl[v].name, "_valid"}, 32'(out_valid), 32'd1);
        chk({tbl[v].name, "_data"}, 32'(out_data), 32'(pk0[16*b +: 16]));
        chk({tbl[v].name, "_last"}, 32'(out_last), 32'(tbl[v].last_mask[b]));
        @(negedge clk);
      end
      chk({tbl[v].name, "_idle_valid"}, 32'(out_valid), 32'd0);
      chk({tbl[v].name, "_idle_busy"}, 32'(busy), 32'd0);
    end

    // Back-pressure pattern 1,0,0,1,...
    pops = 0;
    step(1'b1, 1'b0, pk0, MAC_QUAD);
    guard = 0;
    while (rem > 0 && guard < 60) begin
      step(1'b0, (guard % 3) == 0, pk1, MAC_DUAL);
      guard++;
    end
    chk("bp_beats", 32'(pops), 32'd8);
    step(1'b0, 1'b1, pk1, MAC_DUAL);

    // Capture at beat 3 is dropped; capture on the final edge chains.
    step(1'b1, 1'b1, pk0, MAC_SINGLE);
    guard = 0;
    while (rem > 5 && guard < 20) begin step(1'b0, 1'b1, pk0, MAC_SINGLE); guard++; end
    step(1'b1, 1'b1, pk1, MAC_QUAD);
    guard = 0;
    while (rem > 1 && guard < 20) begin step(1'b0, 1'b1, pk0, MAC_SINGLE); guard++; end
    step(1'b1, 1'b1, pk1, MAC_DUAL);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_beat0", 32'(out_data), 32'(pk1[15:0]));
    guard = 0;
    while (rem > 0 && guard < 20) begin step(1'b0, 1'b1, pk0, MAC_SINGLE); guard++; end
    step(1'b0, 1'b1, pk0, MAC_SINGLE);

    // Asynchronous reset during beat 4.
    step(1'b1, 1'b1, pk0, MAC_QUAD);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, pk0, MAC_QUAD);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    exp_q.delete(); rem = 0; exp_drop = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b1, {96'h0, 32'hDEADBEEF}, MAC_QUAD);
    chk("restart_beat0", 32'(out_data), 32'h0000BEEF);
    guard = 0;
    while (rem > 0 && guard < 20) begin step(1'b0, 1'b1, pk0, MAC_QUAD); guard++; end

`ifdef MAC_OUT_SER_PARITY_EN
    step(1'b1, 1'b1, {96'h0, 32'h00030007}, MAC_QUAD);
    chk("parity_0007", 32'(out_parity), 32'd1);
    step(1'b0, 1'b1, pk0, MAC_QUAD);
    chk("parity_0003", 32'(out_parity), 32'd0);
    guard = 0;
    while (rem > 0 && guard < 20) begin step(1'b0, 1'b1, pk0, MAC_QUAD); guard++; end
`endif

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      pkr = {$urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, pkr, 2'($urandom_range(0, 3)));
    end
    guard = 0;
    while (rem > 0 && guard < 40) begin step(1'b0, 1'b1, pk0, MAC_SINGLE); guard++; end
    chk("drain_done", 32'(rem), 32'd0);
    step(1'b0, 1'b1, pk0, MAC_SINGLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mac_out_serializer.md
Name: mac_out_serializer

Overview:
- Downstream of mac_acc_block_2. Captures its four MAC_ACC_WIDTH outputs (out0..out3) on a capture pulse.
- Streams the captured values as narrow beats over a valid/ready interface to the array output bus.
- Packet framing (out_last) follows the precision mode latched at capture: single, dual or quad.
- Frees the MAC array from back-pressure: one capture can be held while the next accumulation proceeds.

Parameters:
- MAC_MIN_WIDTH, 8, minimum MAC lane width.
- MAC_ACC_WIDTH, 4*MAC_MIN_WIDTH, width of each accumulator word.
- OUT_WIDTH, MAC_ACC_WIDTH/2, beat width. Must divide MAC_ACC_WIDTH.
- BEATS_PER_WORD, MAC_ACC_WIDTH/OUT_WIDTH, derived; 2 at defaults.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- cap  in  1  capture pulse: sample in0..in3 and mode this cycle.
- mode  in  2  precision mode, encodings MAC_SINGLE/MAC_DUAL/MAC_QUAD from mac_const.vh (same bits as cfg[1:0] of the accumulator block).
- in0..in3  in  MAC_ACC_WIDTH each  accumulator outputs; in0 is least significant.
- out_data  out  OUT_WIDTH  current beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  sink ready.
- out_last  out  1  final beat of a result.
- busy  out  1  capture buffer occupied.
- cap_drop  out  1  one-cycle pulse: a capture was rejected.

Behaviour:
- Reset (rst low, asynchronous): out_valid=0, out_last=0, out_data=0, busy=0, cap_drop=0, state=IDLE, beat counter=0. Any stream in progress is abandoned. Normal operation resumes on the first clk edge after rst deasserts.
- FSM states: IDLE, SEND.
- IDLE, cap=1:
  - Load the shift register with {in3,in2,in1,in0}.
  - Latch mode; reserved encodings are latched as MAC_SINGLE.
  - Clear the beat counter and enter SEND.
- Latency: cap at edge N gives out_valid=1 with beat 0 (in0 low OUT_WIDTH bits) after edge N.
- Beat order: least significant first, in0 then in1, in2, in3. Total beats = 4*BEATS_PER_WORD (8 at defaults).
- Handshake:
  - A beat transfers on an edge where out_valid && out_ready.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - out_valid never drops without a transfer, except on reset.
- out_last is asserted on the final beat of each result:
  - single: every BEATS_PER_WORD beats (4 packets).
  - dual: every 2*BEATS_PER_WORD beats (2 packets).
  - quad: only on the final beat (1 packet).
- End of capture: on the final beat's transfer, return to IDLE (out_valid=0), unless cap=1 on that same edge.
- Capture on the final transfer edge: the new capture is accepted and its beat 0 is presented next cycle, so back-to-back streams have no bubble.
- Capture rejected: cap=1 while in SEND and not on the final transfer edge.
  - The capture is dropped and cap_drop pulses high for exactly one cycle after that edge.
  - The stream in progress is unaffected.
- busy = (state==SEND).
- out_data and out_last come straight from registers, with no combinational path from out_ready. The only combinational path is out_ready into next-state logic.
- The beat counter is log2(4*BEATS_PER_WORD) bits wide and wraps to 0 on the final transfer.

Optional Feature:
- Macro: MAC_OUT_SER_PARITY_EN.
- When defined:
  - Adds output out_parity (1 bit) = even parity (XOR reduction) of out_data.
  - out_parity is registered alongside out_data and held stable under the same rule.
  - out_parity resets to 0.
- When undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header mac_const.vh:
  - MAC_SINGLE/MAC_DUAL/MAC_QUAD encodings (already present).
  - New constants MAC_SER_IDLE and MAC_SER_SEND for the state encoding.
- One sub-module: mac_ser_last_gen, the combinational out_last decision from the beat counter and the latched mode.
- The shift register, FSM and handshake stay in the top module.

Test Plan:
- Quad framing, sink always ready. Reset, then cap with in0=0x11112222, in1=0x33334444, in2=0x55556666, in3=0x77778888, mode=QUAD, out_ready=1.
  - Expect 8 beats: 0x2222, 0x1111, 0x4444, 0x3333, 0x6666, 0x5555, 0x8888, 0x7777.
  - out_last only on beat 7; busy low the cycle after.
- Single framing. Same data, mode=SINGLE → out_last high on beats 1, 3, 5, 7. Dual → out_last high on beats 3, 7. Mode 2'b11 → framing identical to single.
- Back-pressure: toggle out_ready 1,0,0,1,…
  - out_data and out_last are held while out_ready=0.
  - No beat is duplicated or lost; a scoreboard receives exactly 8 beats.
- Capture timing.
  - cap at beat 3 → cap_drop one-cycle pulse; the original stream completes unchanged.
  - cap on the final transfer edge → next stream's beat 0 appears the following cycle, with no gap in out_valid.
- Reset mid-stream: assert rst low during beat 4 → outputs zero immediately, without waiting for a clock edge. After release, cap with in0=0xDEADBEEF, quad mode → the stream starts cleanly at 0xBEEF.
- With MAC_OUT_SER_PARITY_EN defined: beat 0x0007 → out_parity=1; beat 0x0003 → out_parity=0.
